// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: z = x + ~y + 1 evaluated one SLICE-bit slice per clock, LSB first.
// Results and ALU-style flags update together on the done edge; WIDTH must be a multiple of SLICE.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_shadow;
    logic [CW-1:0]    r_cnt;
    logic             r_cin;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_sign;
    logic             r_zero;
    logic             r_carry;
    logic             r_parity;
    logic             r_ovf;

    logic [SLICE-1:0] w_xs;
    logic [SLICE-1:0] w_ys;
    logic [SLICE:0]   w_sum;
    logic [WIDTH-1:0] w_full;

    assign w_xs  = r_x[r_cnt*SLICE +: SLICE];
    assign w_ys  = r_y[r_cnt*SLICE +: SLICE];
    assign w_sum = {1'b0, w_xs} + {1'b0, ~w_ys} + {{SLICE{1'b0}}, r_cin};

    // Shadow with the current slice merged in; on the last step this is the full difference.
    always_comb begin
        w_full = r_shadow;
        w_full[r_cnt*SLICE +: SLICE] = w_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_cin    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= '0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_parity <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_cin   <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_shadow <= w_full;
                    r_cin    <= w_sum[SLICE];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_z      <= w_full;
                        r_sign   <= w_full[WIDTH-1];
                        r_zero   <= (w_full == '0);
                        r_carry  <= w_sum[SLICE];
                        r_parity <= ~^w_full;
                        r_ovf    <= (r_x[WIDTH-1] != r_y[WIDTH-1]) &&
                                    (w_full[WIDTH-1] != r_x[WIDTH-1]);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign z        = r_z;
    assign sign     = r_sign;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign parity   = r_parity;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor: hand-computed results, flags, latency and handshake.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] z;
    logic        sign, zero, carry, parity, overflow;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .z(z), .sign(sign), .zero(zero),
        .carry(carry), .parity(parity), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait for done; lat = negedges after start dropped, -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; x = a; y = b;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
        #12;
        checks++;
        if ({busy, done, z, sign, zero, carry, parity, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b z=%h flags=%b%b%b%b%b, want all 0",
                     busy, done, z, sign, zero, carry, parity, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [15:0] vx [6] = '{16'h8FFF, 16'h0002, 16'hAAAA, 16'h8000, 16'h0000, 16'h7FFF};
        logic [15:0] vy [6] = '{16'h8000, 16'hFFFE, 16'hAAAA, 16'h0001, 16'h0001, 16'hFFFF};
        logic [15:0] ez [6] = '{16'h0FFF, 16'h0004, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
        // {sign, zero, carry, parity, overflow}
        logic [4:0]  ef [6] = '{5'b00110, 5'b00000, 5'b01110, 5'b00101, 5'b10010, 5'b10001};
        int lat;
        for (int k = 0; k < 6; k++) begin
            run_op(vx[k], vy[k], lat);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL latency_%0d: got %0d, want 4", k, lat);
            end
            checks++;
            if (z !== ez[k]) begin
                errors++;
                $display("FAIL result_%0d: %h-%h got z=%h, want %h", k, vx[k], vy[k], z, ez[k]);
            end
            checks++;
            if ({sign, zero, carry, parity, overflow} !== ef[k]) begin
                errors++;
                $display("FAIL flags_%0d: got %b, want %b", k,
                         {sign, zero, carry, parity, overflow}, ef[k]);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done_%0d: got %b, want 0", k, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] old_z;
        int ndone;
        old_z = z;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; x = 16'h1234; y = 16'h0034;
        @(negedge clk);
        x = 16'hFFFF; y = 16'h0001;   // start stays high: re-request while busy
        @(negedge clk);
        if (done) ndone++;
        x = 16'h5555; y = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        if (done) ndone++;
        checks++;
        if (z !== old_z) begin
            errors++;
            $display("FAIL z_hold_during_run: got %h, want %h", z, old_z);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    checks++;
                    if (i != 1) begin
                        errors++;
                        $display("FAIL ignored_start_latency: done at slot %0d, want 1", i);
                    end
                    checks++;
                    if (z !== 16'h1200 || {sign, zero, carry, parity, overflow} !== 5'b00110) begin
                        errors++;
                        $display("FAIL ignored_start_result: got z=%h flags=%b, want 1200 00110",
                                 z, {sign, zero, carry, parity, overflow});
                    end
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL single_done: got %0d done pulses, want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; x = 16'h4321; y = 16'h0101;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, z, sign, zero, carry, parity, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b z=%h flags=%b%b%b%b%b, want all 0",
                     busy, done, z, sign, zero, carry, parity, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL no_done_after_abort: got %0d active cycles, want 0", ndone);
        end
        run_op(16'h0009, 16'h0003, lat);
        checks++;
        if (lat != 4 || z !== 16'h0006 || {sign, zero, carry, parity, overflow} !== 5'b00110) begin
            errors++;
            $display("FAIL op_after_reset: got lat=%0d z=%h flags=%b, want 4 0006 00110",
                     lat, z, {sign, zero, carry, parity, overflow});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vx [4] = '{16'h1000, 16'h0005, 16'hFFFF, 16'h0100};
        logic [15:0] vy [4] = '{16'h0001, 16'h0007, 16'hFFFF, 16'h0001};
        logic [15:0] ez [4] = '{16'h0FFF, 16'hFFFE, 16'h0000, 16'h00FF};
        logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int k;
        int lat;
        k = 0;
        @(negedge clk);
        start = 1'b1; x = vx[0]; y = vy[0];
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (done !== (i % 5 == 0) || busy !== !(i % 5 == 0)) begin
                errors++;
                $display("FAIL b2b_handshake_%0d: got done=%b busy=%b, want done=%b busy=%b",
                         i, done, busy, (i % 5 == 0), !(i % 5 == 0));
            end
            if (done && k < 3) begin
                checks++;
                if (z !== ez[k] || carry !== ec[k]) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got z=%h carry=%b, want %h %b",
                             k, z, carry, ez[k], ec[k]);
                end
                k++;
                x = vx[k]; y = vy[k];
            end
        end
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 4 || z !== ez[3] || carry !== ec[3]) begin
            errors++;
            $display("FAIL b2b_last: got lat=%0d z=%h carry=%b, want 4 %h %b",
                     lat, z, carry, ez[3], ec[3]);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
